// File: rtl/ext_arbiter.sv
// ext_arbiter: shares one immediate sign/zero-extension unit between two requesters
// (0 = decode, 1 = branch-target precompute) with round-robin grant and valid/ready
// handshakes on both sides. Illegal mode 2'b11 is rejected locally.
// Optional feature: define EXT_ARB_ERRCNT_EN to add the saturating err_count output.
module ext_arbiter #(
  parameter logic        RR_INIT  = 1'b0,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_instr0,
  input  logic [15:0] req_instr1,
  input  logic [1:0]  req_mode0,
  input  logic [1:0]  req_mode1,
  output logic [15:0] ext_in,
  output logic [1:0]  ext_mode,
  input  logic [15:0] ext_out,
  input  logic        ext_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err
`ifdef EXT_ARB_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {StIdle, StExt, StRsp} state_e;

  localparam logic [1:0] ModeIllegal = 2'b11;

  state_e      state;
  // Requester favoured when both are valid; flips away from each accepted requester.
  logic        rr_fav;
  logic        grant_id;
  logic [15:0] instr_sel;
  logic [1:0]  mode_sel;

  // Arbitration: one-hot ready to the winning valid requester, only while idle.
  always_comb begin
    req_ready = 2'b00;
    grant_id  = rr_fav;
    if (req_valid == 2'b11) begin
      grant_id = rr_fav;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
    if ((state == StIdle) && (req_valid != 2'b00)) begin
      req_ready[grant_id] = 1'b1;
    end
    instr_sel = grant_id ? req_instr1 : req_instr0;
    mode_sel  = grant_id ? req_mode1 : req_mode0;
  end

  // Main FSM: latch the granted operand, capture the extender result, hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      rr_fav    <= RR_INIT;
      ext_in    <= 16'h0000;
      ext_mode  <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_ready != 2'b00) begin
            ext_in   <= instr_sel;
            ext_mode <= mode_sel;
            rsp_id   <= grant_id;
            rr_fav   <= ~grant_id;
            state    <= StExt;
          end
        end
        StExt: begin
          // Illegal mode never reaches the consumer as data; extender output is ignored.
          if (ext_mode == ModeIllegal) begin
            rsp_data <= 16'h0000;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= ext_out;
            rsp_err  <= ext_err;
          end
          rsp_valid <= 1'b1;
          state     <= StRsp;
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef EXT_ARB_ERRCNT_EN
  // Saturating count of error responses, counted at the response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (rsp_valid && rsp_ready && rsp_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// Bench for ext_arbiter: directed scenarios followed by randomized traffic, all checked
// against a transaction-level reference model. Define EXT_ARB_ERRCNT_EN to also cover
// the saturating error counter (instantiated with a 2-bit width).
module tb_ext_arbiter;

`ifdef EXT_ARB_ERRCNT_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_instr0, req_instr1;
  logic [1:0]  req_mode0, req_mode1;
  logic [15:0] ext_in;
  logic [1:0]  ext_mode;
  logic [15:0] ext_out;
  logic        ext_err;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic        err_inj;
`ifdef EXT_ARB_ERRCNT_EN
  logic [CW-1:0] err_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (transaction level).
  int          m_phase;   // 0 idle, 1 extending, 2 response pending
  logic        m_fav;
  logic        m_id;
  logic [15:0] m_instr;
  logic [1:0]  m_mode;
  logic [15:0] m_data;
  logic        m_err;
  int          m_cnt;

  ext_arbiter #(.RR_INIT(1'b0), .ERRCNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_instr0 (req_instr0),
    .req_instr1 (req_instr1),
    .req_mode0  (req_mode0),
    .req_mode1  (req_mode1),
    .ext_in     (ext_in),
    .ext_mode   (ext_mode),
    .ext_out    (ext_out),
    .ext_err    (ext_err),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
`ifdef EXT_ARB_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] extend(input logic [15:0] v, input logic [1:0] m);
    case (m)
      2'b00:   return {11'd0, v[4:0]};
      2'b01:   return {8'd0, v[7:0]};
      2'b10:   return {{11{v[4]}}, v[4:0]};
      default: return 16'h0000;
    endcase
  endfunction

  // Environment extender: garbage on the illegal mode so the DUT must ignore it.
  always_comb begin
    ext_out = (ext_mode == 2'b11) ? 16'hBEEF : extend(ext_in, ext_mode);
    ext_err = err_inj;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_fav = 1'b0; m_id = 1'b0; m_instr = '0; m_mode = '0;
    m_data = '0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [15:0] i0, input logic [1:0] md0,
                       input logic [15:0] i1, input logic [1:0] md1, input logic rr);
    req_valid = v; req_instr0 = i0; req_mode0 = md0;
    req_instr1 = i1; req_mode1 = md1; rsp_ready = rr;
  endtask

  // Check all outputs against the model, advance one clock, update the model.
  task automatic tick();
    logic [1:0] er;
    logic       win;
    #1;
    er  = 2'b00;
    win = 1'b0;
    if (m_phase == 0 && req_valid != 2'b00) begin
      win = (req_valid == 2'b11) ? m_fav : req_valid[1];
      er  = win ? 2'b10 : 2'b01;
    end
    check("req_ready", {30'd0, req_ready}, {30'd0, er});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_phase == 2});
    check("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    check("rsp_data", {16'd0, rsp_data}, {16'd0, m_data});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
    check("ext_in", {16'd0, ext_in}, {16'd0, m_instr});
    check("ext_mode", {30'd0, ext_mode}, {30'd0, m_mode});
`ifdef EXT_ARB_ERRCNT_EN
    check("err_count", {{(32-CW){1'b0}}, err_count}, m_cnt);
`endif
    @(posedge clk);
    case (m_phase)
      0: if (er != 2'b00) begin
        m_id    = win;
        m_instr = win ? req_instr1 : req_instr0;
        m_mode  = win ? req_mode1 : req_mode0;
        m_fav   = ~win;
        m_phase = 1;
      end
      1: begin
        m_data  = extend(m_instr, m_mode);
        m_err   = (m_mode == 2'b11) || err_inj;
        m_phase = 2;
      end
      default: if (rsp_ready) begin
        if (m_err && m_cnt < (1 << CW) - 1) m_cnt++;
        m_phase = 0;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    err_inj = 1'b0;
    drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b0);
    apply_reset();

    // Reset state.
    tick();

    // Both valid continuously, rsp_ready high: grants alternate 0,1,0,1 every 3 cycles.
    apply_reset();
    drive(2'b11, 16'h0013, 2'b00, 16'h00A5, 2'b01, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) begin
        #1;
        check("grant_order", {30'd0, req_ready}, ((i / 3) % 2 == 1) ? 32'd2 : 32'd1);
      end
      tick();
    end
    drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    tick(); tick(); tick();

    // Only req0: 0x001F sign-extended from 5 bits.
    drive(2'b01, 16'h001F, 2'b10, 16'h0, 2'b00, 1'b1);
    #1;
    check("t1_ready", {30'd0, req_ready}, 32'd1);
    tick();
    drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    tick();
    #1;
    check("t1_valid", {31'd0, rsp_valid}, 32'd1);
    check("t1_data", {16'd0, rsp_data}, 32'hFFFF);
    check("t1_id", {31'd0, rsp_id}, 32'd0);
    tick();

    // req1 mode 01 with a stalled consumer: response held for 5 cycles.
    drive(2'b10, 16'h0, 2'b00, 16'h12F0, 2'b01, 1'b0);
    tick(); tick();
    drive(2'b11, 16'h0007, 2'b00, 16'h12F0, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_hold", {16'd0, rsp_data}, 32'h00F0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    tick(); tick(); tick();

    // Illegal mode from req0.
    apply_reset();
    drive(2'b01, 16'hFFFF, 2'b11, 16'h0, 2'b00, 1'b1);
    tick();
    drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    tick();
    #1;
    check("t5_err", {31'd0, rsp_err}, 32'd1);
    check("t5_data", {16'd0, rsp_data}, 32'h0);
    tick(); tick();
`ifdef EXT_ARB_ERRCNT_EN
    check("t5_cnt", {{(32-CW){1'b0}}, err_count}, 32'd1);
`endif

    // Reset while a response is pending; favoured requester must return to RR_INIT.
    drive(2'b01, 16'h0004, 2'b00, 16'h0, 2'b00, 1'b0);
    tick();
    drive(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("t6_async", {31'd0, rsp_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 16'h0001, 2'b00, 16'h0002, 2'b00, 1'b1);
    #1;
    check("t6_rearb", {30'd0, req_ready}, 32'd1);
    tick(); tick(); tick();

`ifdef EXT_ARB_ERRCNT_EN
    // Five illegal requests saturate a 2-bit counter.
    apply_reset();
    drive(2'b10, 16'h0, 2'b00, 16'h1234, 2'b11, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("t7_sat", {{(32-CW){1'b0}}, err_count}, 32'd3);
`endif

    // Randomized traffic.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 16'($urandom), 2'($urandom), 16'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 6));
      err_inj = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
